// File: rtl/timer_core.sv
// General Timer counting engine: prescaler, up/down one-shot/periodic counter,
// PWM output, external-clock input and input capture.
// Ports:
//   i_clk, i_rst        clock and synchronous active-high reset
//   i_en, i_mode, i_dir counter enable, 0=one-shot/1=periodic, 0=down/1=up
//   i_pre_en, i_pre_val prescaler enable and divisor minus one
//   i_ext_en, i_ext_in  count rising edges of async i_ext_in instead of clk
//   i_pwm_en, i_cmp_val PWM enable and compare value
//   i_cap_en, i_cap_in  capture enable and async capture trigger
//   i_load_val          reload / terminal value
//   i_load_cmd          one-cycle load strobe
//   o_current_val       live count
//   o_capture_val       count latched at capture
//   o_capture_stb       one-cycle capture pulse
//   o_core_irq          one-cycle expiry pulse
//   o_pwm_o             PWM output
module timer_core #(
  parameter int CNT_W       = 32,
  parameter int PRE_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic             i_dir,
  input  logic             i_pre_en,
  input  logic [PRE_W-1:0] i_pre_val,
  input  logic             i_ext_en,
  input  logic             i_pwm_en,
  input  logic             i_cap_en,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic [CNT_W-1:0] i_cmp_val,
  input  logic             i_load_cmd,
  input  logic             i_ext_in,
  input  logic             i_cap_in,
  output logic [CNT_W-1:0] o_current_val,
  output logic [CNT_W-1:0] o_capture_val,
  output logic             o_capture_stb,
  output logic             o_core_irq,
  output logic             o_pwm_o
);

  logic [SYNC_STAGES-1:0] r_ext_sync;
  logic [SYNC_STAGES-1:0] r_cap_sync;
  logic                   r_ext_q;
  logic                   r_cap_q;

  logic [CNT_W-1:0] r_count;
  logic [PRE_W-1:0] r_pre_cnt;
  logic             r_done;
  logic [CNT_W-1:0] r_capture_val;
  logic             r_capture_stb;
  logic             r_core_irq;
  logic             r_pwm;

  logic             w_ext_rise;
  logic             w_cap_rise;
  logic             w_src;
  logic             w_pre_hit;
  logic             w_tick;
  logic             w_step;
  logic             w_at_end;
  logic [CNT_W-1:0] w_reload;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ext_sync <= '0;
      r_cap_sync <= '0;
      r_ext_q    <= 1'b0;
      r_cap_q    <= 1'b0;
    end else begin
      r_ext_sync <= {r_ext_sync[SYNC_STAGES-2:0], i_ext_in};
      r_cap_sync <= {r_cap_sync[SYNC_STAGES-2:0], i_cap_in};
      r_ext_q    <= r_ext_sync[SYNC_STAGES-1];
      r_cap_q    <= r_cap_sync[SYNC_STAGES-1];
    end
  end

  assign w_ext_rise = r_ext_sync[SYNC_STAGES-1] & ~r_ext_q;
  assign w_cap_rise = r_cap_sync[SYNC_STAGES-1] & ~r_cap_q;

  assign w_src     = i_ext_en ? w_ext_rise : 1'b1;
  assign w_pre_hit = (r_pre_cnt == i_pre_val);
  assign w_tick    = i_pre_en ? (w_src & w_pre_hit) : w_src;
  assign w_step    = i_en & w_tick & ~r_done;
  assign w_reload  = i_dir ? '0 : i_load_val;

  // Up count expires at or beyond the terminal value so that a
  // load_val lowered below the live count still terminates.
  assign w_at_end = i_dir ? (r_count >= i_load_val)
                          : (r_count == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count       <= '0;
      r_pre_cnt     <= '0;
      r_done        <= 1'b0;
      r_capture_val <= '0;
      r_capture_stb <= 1'b0;
      r_core_irq    <= 1'b0;
      r_pwm         <= 1'b0;
    end else begin
      r_core_irq <= 1'b0;
      if (i_load_cmd) begin
        r_count   <= w_reload;
        r_pre_cnt <= '0;
        r_done    <= 1'b0;
      end else begin
        if (i_en & w_src & i_pre_en) begin
          r_pre_cnt <= w_pre_hit ? '0 : r_pre_cnt + PRE_W'(1);
        end
        if (w_step) begin
          if (w_at_end) begin
            r_core_irq <= 1'b1;
            if (i_mode) begin
              r_count <= w_reload;
            end else begin
              r_done <= 1'b1;
            end
          end else if (i_dir) begin
            r_count <= r_count + CNT_W'(1);
          end else begin
            r_count <= r_count - CNT_W'(1);
          end
        end
      end
      // Capture and PWM both see the count from before this edge.
      r_capture_stb <= i_cap_en & w_cap_rise;
      if (i_cap_en & w_cap_rise) begin
        r_capture_val <= r_count;
      end
      r_pwm <= i_pwm_en & (r_count < i_cmp_val);
    end
  end

  assign o_current_val = r_count;
  assign o_capture_val = r_capture_val;
  assign o_capture_stb = r_capture_stb;
  assign o_core_irq    = r_core_irq;
  assign o_pwm_o       = r_pwm;

endmodule
